cla64_operand_loader: RTL and testbench

Sequential front/back-end for the 64-bit carry lookahead adder. It assembles two 64-bit operands from a narrow 16-bit input stream and drives them, with a carry-in, onto the adder's A/B/Cin inputs. It then captures the adder's Sum/Cout into a result register and presents the result on a valid/ready output handshake. It sits directly upstream of the adder and consumes the adder's combinational result.

---
 rtl/cla64_operand_loader.sv | 115 +++++++++++
 tb/tb_cla64_operand_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cla64_operand_loader.sv
// Operand loader / result capture wrapped around the external 64-bit CLA.
// Streams A then B in LSB-first beats, fires one ADD cycle, holds the result until it is taken.
module cla64_operand_loader #(
  parameter  int BEAT_W = 16,
  localparam int BEATS  = 64 / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_cin,
  output logic [63:0]       op_a,
  output logic [63:0]       op_b,
  output logic              op_cin,
  output logic              op_valid,
  input  logic [63:0]       add_sum,
  input  logic              add_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [63:0]       res_sum,
  output logic              res_cout
);

  // state  | meaning
  // LOAD_A | collecting operand A beats
  // LOAD_B | collecting operand B beats, carry-in taken with the last one
  // ADD    | operands stable, adder result captured at the closing edge
  // HOLD   | result presented until res_ready

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             beat_xfer;
  logic             last_beat;
  logic             res_xfer;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign beat_xfer = in_valid && in_ready;
  assign res_xfer  = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    op_valid  = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = !rst;
        if (beat_xfer && last_beat) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = !rst;
        if (beat_xfer && last_beat) state_nxt = ADD;
      end
      ADD: begin
        op_valid  = !rst;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (res_xfer) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // Operands are deliberately not cleared between transactions; every slice is rewritten by the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else begin
      if (beat_xfer) begin
        for (int i = 0; i < BEATS; i++) begin
          if (cnt == CNT_W'(i)) begin
            if (state == LOAD_A) op_a[i*BEAT_W +: BEAT_W] <= in_data;
            else                 op_b[i*BEAT_W +: BEAT_W] <= in_data;
          end
        end
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        if (state == LOAD_B && last_beat) op_cin <= in_cin;
      end
      if (state == ADD) begin
        res_sum   <= add_sum;
        res_cout  <= add_cout;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_xfer) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla64_operand_loader.sv
// Bench for cla64_operand_loader: behavioural adder on the op_* outputs, scoreboard of expected results.
module tb_cla64_operand_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_cin;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_cin;
  logic        op_valid;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_sum;
  logic        res_cout;

  int errors = 0;
  int checks = 0;
  logic [64:0] sb[$];

  cla64_operand_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_valid(op_valid),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout)
  );

  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b} + {64'd0, op_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A result is consumed at the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", {res_cout, res_sum}, 65'd0);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        chk("sb_sum", {1'b0, res_sum}, {1'b0, e[63:0]});
        chk("sb_cout", {64'd0, res_cout}, {64'd0, e[64]});
      end
    end
  end

  task automatic beat(input logic [15:0] d, input logic c, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 16'($urandom);
      in_cin  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 65'd0, 65'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cin   = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // noise: random gaps, 3 idle cycles before B2, in_cin=1 on non-final beats.
  task automatic send_txn(input logic [63:0] a, input logic [63:0] b, input logic c,
                          input logic [64:0] exp, input logic noise);
    logic [15:0] d;
    logic        cv;
    int          gap;
    sb.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      d   = (i < 4) ? a[i*16 +: 16] : b[(i-4)*16 +: 16];
      cv  = (i == 7) ? c : noise;
      gap = !noise ? 0 : (i == 6) ? 3 : int'($urandom_range(0, 2));
      beat(d, cv, gap);
    end
    chk("add_op_valid", {64'd0, op_valid}, 65'd1);
    chk("add_in_ready", {64'd0, in_ready}, 65'd0);
    chk("add_res_valid", {64'd0, res_valid}, 65'd0);
    chk("add_op_a", {1'b0, op_a}, {1'b0, a});
    chk("add_op_b", {1'b0, op_b}, {1'b0, b});
    chk("add_op_cin", {64'd0, op_cin}, {64'd0, c});
    @(posedge clk); #1;
    chk("hold_res_valid", {64'd0, res_valid}, 65'd1);
    chk("hold_res_sum", {1'b0, res_sum}, {1'b0, exp[63:0]});
    chk("hold_res_cout", {64'd0, res_cout}, {64'd0, exp[64]});
    chk("hold_op_valid", {64'd0, op_valid}, 65'd0);
    if (res_ready) begin
      @(posedge clk); #1;
      chk("done_res_valid", {64'd0, res_valid}, 65'd0);
      chk("done_in_ready", {64'd0, in_ready}, 65'd1);
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_res_valid", {64'd0, res_valid}, 65'd0);
    chk("rst_op_a", {1'b0, op_a}, 65'd0);
    chk("rst_res_sum", {1'b0, res_sum}, 65'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {64'd0, in_ready}, 65'd1);

    // basic, cross-half carry, overflow cases
    send_txn(64'd1, 64'd1, 1'b0, 65'h2, 1'b0);
    send_txn(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 65'h0_0000_0001_0000_0000, 1'b0);
    send_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0}, 1'b0);
    send_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'd0}, 1'b0);

    // gaps and cin noise on non-final beats
    send_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
             65'h0_2222_2222_2222_2211, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'($urandom);
      send_txn(a, b, c, {1'b0, a} + {1'b0, b} + {64'd0, c}, 1'b1);
    end

    // back-pressure on the result
    res_ready = 1'b0;
    send_txn(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1,
             65'h0_DEAD_BEF0_0000_0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_res_valid", {64'd0, res_valid}, 65'd1);
      chk("bp_res_sum", {1'b0, res_sum}, 65'h0_DEAD_BEF0_0000_0001);
      chk("bp_in_ready", {64'd0, in_ready}, 65'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {64'd0, in_ready}, 65'd1);
    chk("bp_release_res_valid", {64'd0, res_valid}, 65'd0);

    // reset after 5 beats
    for (int i = 0; i < 5; i++) beat(16'hA5A5 + 16'(i), 1'b1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_op_a", {1'b0, op_a}, 65'd0);
    chk("mid_rst_op_b", {1'b0, op_b}, 65'd0);
    chk("mid_rst_op_cin", {64'd0, op_cin}, 65'd0);
    chk("mid_rst_op_valid", {64'd0, op_valid}, 65'd0);
    chk("mid_rst_res_valid", {64'd0, res_valid}, 65'd0);
    chk("mid_rst_res", {res_cout, res_sum}, 65'd0);
    chk("mid_rst_in_ready", {64'd0, in_ready}, 65'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", {64'd0, in_ready}, 65'd1);
    send_txn(64'd3, 64'd4, 1'b0, 65'd7, 1'b0);

    // reset while holding a result: it is dropped without a handshake
    res_ready = 1'b0;
    send_txn(64'd100, 64'd23, 1'b0, 65'd123, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("hold_rst_res_valid", {64'd0, res_valid}, 65'd0);
    chk("hold_rst_res", {res_cout, res_sum}, 65'd0);
    rst = 1'b0;
    #1;
    chk("hold_rel_in_ready", {64'd0, in_ready}, 65'd1);
    res_ready = 1'b1;

    // back-to-back; second load must fully replace the first operands
    send_txn(64'hFFFF, 64'd1, 1'b0, 65'h1_0000, 1'b0);
    send_txn(64'h10, 64'h20, 1'b0, 65'h30, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drain", 65'(sb.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
